// File: rtl/stopwatch_pkg.sv
// Shared types and field widths for the stopwatch control sequencer and datapath.
package stopwatch_pkg;

  // Run/pause FSM encoding; the numeric values are visible to the datapath and must not move.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // Counter field widths (seconds, minutes, hours).
  localparam int SEC_W  = 7;
  localparam int MIN_W  = 7;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/sw_tick_prescaler.sv
// Divides clk down to a one-cycle count-enable pulse every TICK_DIV enabled cycles.
// The count is held while en is low, so sub-tick phase survives a pause; clr zeroes it.
module sw_tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          tick_reg;

  // Phase counter and registered tick: tick fires the cycle after the count reaches LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (clr) begin
        cnt_reg <= '0;
      end else if (en) begin
        if (cnt_reg == LAST) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/stopwatch_seq_ctrl.sv
// Stopwatch control sequencer: turns synchronised button pulses into counter ticks,
// a sync clear and lap-register write strobes, and raises a sticky alarm indicator.
module stopwatch_seq_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int LAP_DEPTH = 4,
  parameter int AW        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_start_stop,
  input  logic              btn_lap,
  input  logic              btn_clear,
  input  logic              alarm_en,
  input  logic [SEC_W-1:0]  alarm_sec,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] cur_hour,
  output logic              tick_en,
  output logic              cnt_clear,
  output logic              lap_we,
  output logic [AW-1:0]     lap_addr,
  output logic              lap_full,
  output logic              running,
  output logic              ring
);

  localparam logic [AW:0] LAP_CNT_FULL = (AW + 1)'(LAP_DEPTH);

  sw_state_t     state_reg, state_next;
  logic [AW:0]   lap_cnt_reg;
  logic [AW-1:0] lap_addr_reg;
  logic          lap_we_reg;
  logic          cnt_clear_reg;
  logic          tick_d_reg;
  logic          ring_reg;

  logic presc_en;
  logic presc_tick;
  logic any_btn;
  logic clr_acc;
  logic ss_acc;
  logic lap_acc;
  logic lap_full_w;
  logic time_match;
  logic alarm_hit;

  // Button arbitration: clear beats start/stop beats lap; clear only counts outside RUN.
  assign any_btn    = btn_start_stop | btn_lap | btn_clear;
  assign lap_full_w = (lap_cnt_reg == LAP_CNT_FULL);
  assign clr_acc    = btn_clear & ((state_reg == IDLE) | (state_reg == PAUSE));
  assign ss_acc     = btn_start_stop & ~btn_clear;
  assign lap_acc    = btn_lap & ~btn_clear & ~btn_start_stop & ~lap_full_w &
                      ((state_reg == RUN) | (state_reg == PAUSE));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ss_acc) state_next = RUN;
      RUN:     if (ss_acc) state_next = PAUSE;
      PAUSE: begin
        if (clr_acc)     state_next = IDLE;
        else if (ss_acc) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; the prescaler counts in every cycle that ends in RUN, which puts the
  // first tick exactly TICK_DIV cycles after the start pulse.
  always_comb begin
    running  = (state_reg == RUN);
    presc_en = (state_next == RUN);
  end

  sw_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (clr_acc),
    .tick  (presc_tick)
  );

  // Lap slot allocation: strobe the current slot the cycle after an accepted lap; no wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_cnt_reg  <= '0;
      lap_addr_reg <= '0;
      lap_we_reg   <= 1'b0;
    end else if (clr_acc) begin
      lap_cnt_reg  <= '0;
      lap_addr_reg <= '0;
      lap_we_reg   <= 1'b0;
    end else begin
      lap_we_reg <= lap_acc;
      if (lap_acc) begin
        lap_addr_reg <= lap_cnt_reg[AW-1:0];
        lap_cnt_reg  <= lap_cnt_reg + 1'b1;
      end
    end
  end

  // Registered counter clear and one-cycle-delayed tick (counters hold the new time then).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_clear_reg <= 1'b0;
      tick_d_reg    <= 1'b0;
    end else begin
      cnt_clear_reg <= clr_acc;
      tick_d_reg    <= presc_tick;
    end
  end

  // Alarm compares only right after a counter update, so a matching time rings once.
  assign time_match = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == alarm_sec);
  assign alarm_hit  = tick_d_reg & alarm_en & (state_reg == RUN) & time_match;

  // Sticky ring: any button or disabling the alarm clears it, winning over a same-cycle hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    ring_reg <= 1'b0;
    else if (any_btn | ~alarm_en) ring_reg <= 1'b0;
    else if (alarm_hit)           ring_reg <= 1'b1;
  end

  assign tick_en   = presc_tick;
  assign cnt_clear = cnt_clear_reg;
  assign lap_we    = lap_we_reg;
  assign lap_addr  = lap_addr_reg;
  assign lap_full  = lap_full_w;
  assign ring      = ring_reg;

endmodule

// File: tb/tb_stopwatch_seq_ctrl.sv
// Directed bench for stopwatch_seq_ctrl with TICK_DIV=4, LAP_DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are read at that point.
module tb_stopwatch_seq_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 4;
  localparam int AW        = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_start_stop = 1'b0;
  logic          btn_lap = 1'b0;
  logic          btn_clear = 1'b0;
  logic          alarm_en = 1'b0;
  logic [6:0]    alarm_sec = '0;
  logic [6:0]    alarm_min = '0;
  logic [4:0]    alarm_hour = '0;
  logic [6:0]    cur_sec;
  logic [6:0]    cur_min;
  logic [4:0]    cur_hour;
  logic          tick_en, cnt_clear, lap_we, lap_full, running, ring;
  logic [AW-1:0] lap_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stopwatch_seq_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .LAP_DEPTH (LAP_DEPTH),
    .AW        (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .alarm_en       (alarm_en),
    .alarm_sec      (alarm_sec),
    .alarm_min      (alarm_min),
    .alarm_hour     (alarm_hour),
    .cur_sec        (cur_sec),
    .cur_min        (cur_min),
    .cur_hour       (cur_hour),
    .tick_en        (tick_en),
    .cnt_clear      (cnt_clear),
    .lap_we         (lap_we),
    .lap_addr       (lap_addr),
    .lap_full       (lap_full),
    .running        (running),
    .ring           (ring)
  );

  // Behavioural model of the hh:mm:ss counter datapath fed by tick_en / cnt_clear.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_sec <= '0; cur_min <= '0; cur_hour <= '0;
    end else if (cnt_clear) begin
      cur_sec <= '0; cur_min <= '0; cur_hour <= '0;
    end else if (tick_en) begin
      if (cur_sec == 7'd59) begin
        cur_sec <= '0;
        cur_min <= cur_min + 7'd1;
      end else begin
        cur_sec <= cur_sec + 7'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; alarm_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    do_reset();
    reset = 1'b1;
    step();
    obs = {tick_en, cnt_clear, lap_we, lap_full, running, ring, lap_addr};
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000", obs);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (running !== 1'b0 || tick_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: running=%b tick_en=%b expected 0 0", running, tick_en);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_tick_run();
    logic exp;
    do_reset();
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // now cycle 1
    n_tests++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL run_running: got %b expected 1", running);
    end
    for (int k = 1; k <= 12; k++) begin
      exp = ((k % 4) == 0);
      n_tests++;
      if (tick_en !== exp) begin
        n_fail++;
        $display("FAIL run_tick_c%0d: got %b expected %b", k, tick_en, exp);
      end
      step();
    end
    $display("[TB] test_tick_run done");
  endtask

  task automatic test_pause_phase();
    logic seen;
    do_reset();
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // cycle 1
    repeat (5) step();                                      // cycle 6, prescaler phase 2
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // paused
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_running: got %b expected 0", running);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      seen = seen | tick_en;
      step();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_no_tick: got tick %b expected 0", seen);
    end
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // resume +1
    n_tests++;
    if (running !== 1'b1 || tick_en !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_r1: running=%b tick_en=%b expected 1 0", running, tick_en);
    end
    step();                                                 // resume +2
    n_tests++;
    if (tick_en !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_phase_tick: got %b expected 1", tick_en);
    end
    $display("[TB] test_pause_phase done");
  endtask

  task automatic test_clear();
    do_reset();
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // c1 RUN
    btn_clear = 1'b1; step(); btn_clear = 1'b0;             // c2
    n_tests++;
    if (running !== 1'b1 || cnt_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_in_run: running=%b cnt_clear=%b expected 1 0", running, cnt_clear);
    end
    btn_lap = 1'b1; step(); btn_lap = 1'b0;                 // c3
    btn_lap = 1'b1; step(); btn_lap = 1'b0;                 // c4
    n_tests++;
    if (lap_we !== 1'b1 || lap_addr !== 2'd1) begin
      n_fail++;
      $display("FAIL clear_pre_lap: lap_we=%b lap_addr=%0d expected 1 1", lap_we, lap_addr);
    end
    step();                                                 // c5, prescaler phase 1 after stop
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // PAUSE
    btn_clear = 1'b1; step(); btn_clear = 1'b0;
    n_tests++;
    if (cnt_clear !== 1'b1 || running !== 1'b0 || lap_addr !== 2'd0 || lap_full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_in_pause: cnt_clear=%b running=%b lap_addr=%0d lap_full=%b expected 1 0 0 0",
               cnt_clear, running, lap_addr, lap_full);
    end
    step();
    n_tests++;
    if (cnt_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_one_cycle: got %b expected 0", cnt_clear);
    end
    btn_lap = 1'b1; step(); btn_lap = 1'b0;
    n_tests++;
    if (lap_we !== 1'b0) begin
      n_fail++;
      $display("FAIL lap_in_idle: got %b expected 0", lap_we);
    end
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // R+1
    repeat (2) step();                                      // R+3
    n_tests++;
    if (tick_en !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_presc_zero_r3: got %b expected 0", tick_en);
    end
    step();                                                 // R+4
    n_tests++;
    if (tick_en !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_presc_zero_r4: got %b expected 1", tick_en);
    end
    $display("[TB] test_clear done");
  endtask

  task automatic test_lap_full();
    logic [AW-1:0] ea;
    logic          ew, ef;
    do_reset();
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_lap = 1'b1; step(); btn_lap = 1'b0;
      ew = (i < 4);
      ef = (i >= 3);
      ea = (i < 4) ? AW'(i) : AW'(3);
      n_tests++;
      if (lap_we !== ew || lap_addr !== ea || lap_full !== ef) begin
        n_fail++;
        $display("FAIL lap_%0d: we=%b addr=%0d full=%b expected %b %0d %b",
                 i, lap_we, lap_addr, lap_full, ew, ea, ef);
      end
      step();
    end
    $display("[TB] test_lap_full done");
  endtask

  task automatic test_alarm();
    logic seen;
    do_reset();
    alarm_sec = 7'd3; alarm_min = '0; alarm_hour = '0; alarm_en = 1'b1;
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // c1
    seen = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      seen = seen | ring;
      step();
    end                                                     // c14
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_early: got %b expected 0", seen);
    end
    n_tests++;
    if (ring !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_ring: got %b expected 1", ring);
    end
    btn_lap = 1'b1; step(); btn_lap = 1'b0;
    n_tests++;
    if (ring !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_btn_clear: got %b expected 0", ring);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      seen = seen | ring;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_retrigger: got %b expected 0", seen);
    end
    alarm_en = 1'b0;
    $display("[TB] test_alarm done");
  endtask

  task automatic test_priority_and_reset();
    logic [7:0] obs;
    do_reset();
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // RUN
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // PAUSE
    btn_lap = 1'b1; step(); btn_lap = 1'b0;
    n_tests++;
    if (lap_we !== 1'b1 || lap_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_pause_lap: we=%b addr=%0d expected 1 0", lap_we, lap_addr);
    end
    btn_clear = 1'b1; btn_start_stop = 1'b1; btn_lap = 1'b1;
    step();
    btn_clear = 1'b0; btn_start_stop = 1'b0; btn_lap = 1'b0;
    n_tests++;
    if (cnt_clear !== 1'b1 || running !== 1'b0 || lap_we !== 1'b0 || lap_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_clear_wins: cnt_clear=%b running=%b lap_we=%b addr=%0d expected 1 0 0 0",
               cnt_clear, running, lap_we, lap_addr);
    end
    btn_start_stop = 1'b1; step(); btn_start_stop = 1'b0;   // RUN
    btn_lap = 1'b1;
    repeat (4) step();
    btn_lap = 1'b0;
    n_tests++;
    if (lap_we !== 1'b1 || lap_full !== 1'b1 || running !== 1'b1 || lap_addr !== 2'd3) begin
      n_fail++;
      $display("FAIL pre_reset_state: we=%b full=%b running=%b addr=%0d expected 1 1 1 3",
               lap_we, lap_full, running, lap_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {tick_en, cnt_clear, lap_we, lap_full, running, ring, lap_addr};
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b expected 00000000", obs);
    end
    do_reset();
    $display("[TB] test_priority_and_reset done");
  endtask

  initial begin
    test_reset();
    test_tick_run();
    test_pause_phase();
    test_clear();
    test_lap_full();
    test_alarm();
    test_priority_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
